// File: rtl/memory_access.sv
// MEM stage of the 5-stage RISC-V pipeline: issues byte/half/word loads and stores
// over a req/ack data-memory port, formats load data and owns the MEM/WB register.
module memory_access #(
   parameter int REG_WIDTH = 32,
   parameter int REG_COUNT = 32,
   parameter int REG_BITS  = $clog2(REG_COUNT)
) (
   input  logic                              clk,
   input  logic                              rstn,
   input  logic                              ex_valid,
   input  logic                              ex_write_en,
   input  logic [REG_BITS-1:0]               ex_write_reg,
   input  logic [REG_WIDTH-1:0]              ex_alu_out,
   input  logic [REG_WIDTH-1:0]              ex_store_data,
   input  logic [REG_WIDTH-1:0]              ex_return_pc,
   input  logic [1:0]                        ex_write_src_sel,
   input  logic                              ex_mem_read,
   input  logic                              ex_mem_write,
   input  logic [2:0]                        ex_funct3,
   output logic                              mem_stall,
   output logic                              dmem_req,
   output logic                              dmem_we,
   output logic [REG_WIDTH-1:0]              dmem_addr,
   output logic [REG_WIDTH-1:0]              dmem_wdata,
   output logic [3:0]                        dmem_be,
   input  logic                              dmem_ack,
   input  logic [REG_WIDTH-1:0]              dmem_rdata,
   output logic                              misalign_err,
   output logic [REG_BITS+3*REG_WIDTH+2:0]   mem_wb_reg
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   // Size/alignment legality of a memory access; stores have no unsigned forms.
   function automatic logic access_legal(input logic [2:0] f3,
                                         input logic [1:0] off,
                                         input logic       is_store);
      logic ok;
      case (f3)
         3'b000:  ok = 1'b1;
         3'b100:  ok = ~is_store;
         3'b001:  ok = ~off[0];
         3'b101:  ok = ~is_store & ~off[0];
         3'b010:  ok = (off == 2'b00);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   state_t                          state_r;
   state_t                          state_next_s;
   logic [1:0]                      offset_s;
   logic                            is_mem_s;
   logic                            legal_s;
   logic                            illegal_s;
   logic                            mem_op_s;
   logic                            stall_s;
   logic [REG_WIDTH-1:0]            shifted_s;
   logic [REG_WIDTH-1:0]            read_data_s;
   logic [REG_WIDTH-1:0]            wdata_s;
   logic [3:0]                      be_s;
   logic                            misalign_r;
   logic [REG_BITS+3*REG_WIDTH+2:0] mem_wb_r;

   assign offset_s  = ex_alu_out[1:0];
   assign is_mem_s  = ex_mem_read | ex_mem_write;
   // Non-memory instructions count as legal so their write_en passes through.
   assign legal_s   = ~is_mem_s | access_legal(ex_funct3, offset_s, ex_mem_write);
   assign illegal_s = ex_valid & is_mem_s & ~legal_s;
   assign mem_op_s  = ex_valid & is_mem_s & legal_s;
   assign stall_s   = mem_op_s & ~dmem_ack & rstn;

   assign dmem_req     = mem_op_s & rstn;
   assign mem_stall    = stall_s;
   assign dmem_we      = ex_mem_write;
   assign dmem_addr    = {ex_alu_out[REG_WIDTH-1:2], 2'b00};
   assign dmem_wdata   = wdata_s;
   assign dmem_be      = be_s;
   assign misalign_err = misalign_r;
   assign mem_wb_reg   = mem_wb_r;
   assign shifted_s    = dmem_rdata >> {offset_s, 3'b000};

   // Store lane replication and byte-enable generation.
   always_comb begin
      wdata_s = {REG_WIDTH{1'b0}};
      be_s    = 4'b0000;
      if (ex_mem_write) begin
         case (ex_funct3)
            3'b000: begin
               wdata_s = {4{ex_store_data[7:0]}};
               be_s    = 4'b0001 << offset_s;
            end
            3'b001: begin
               wdata_s = {2{ex_store_data[15:0]}};
               be_s    = 4'b0011 << {offset_s[1], 1'b0};
            end
            3'b010: begin
               wdata_s = ex_store_data;
               be_s    = 4'b1111;
            end
            default: begin
               wdata_s = {REG_WIDTH{1'b0}};
               be_s    = 4'b0000;
            end
         endcase
      end else begin
         wdata_s = {REG_WIDTH{1'b0}};
         be_s    = 4'b0000;
      end
   end

   // Load data alignment and sign/zero extension.
   always_comb begin
      read_data_s = {REG_WIDTH{1'b0}};
      if (ex_mem_read) begin
         case (ex_funct3)
            3'b000:  read_data_s = {{(REG_WIDTH-8){shifted_s[7]}}, shifted_s[7:0]};
            3'b100:  read_data_s = {{(REG_WIDTH-8){1'b0}}, shifted_s[7:0]};
            3'b001:  read_data_s = {{(REG_WIDTH-16){shifted_s[15]}}, shifted_s[15:0]};
            3'b101:  read_data_s = {{(REG_WIDTH-16){1'b0}}, shifted_s[15:0]};
            3'b010:  read_data_s = shifted_s;
            default: read_data_s = {REG_WIDTH{1'b0}};
         endcase
      end else begin
         read_data_s = {REG_WIDTH{1'b0}};
      end
   end

   // Access FSM next state; a dropped request also returns to IDLE.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (mem_op_s && !dmem_ack) begin
               state_next_s = WAIT;
            end else begin
               state_next_s = IDLE;
            end
         end
         WAIT: begin
            if (dmem_ack || !mem_op_s) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = WAIT;
            end
         end
         default: state_next_s = IDLE;
      endcase
   end

   // Access FSM state register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Sticky misalignment/illegal-access flag, cleared only by reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         misalign_r <= 1'b0;
      end else if (illegal_s) begin
         misalign_r <= 1'b1;
      end
   end

   // MEM/WB pipeline register; bubbles while stalled or without a valid instruction.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mem_wb_r <= '0;
      end else if (stall_s || !ex_valid) begin
         mem_wb_r <= '0;
      end else begin
         mem_wb_r <= {ex_write_en & legal_s, ex_write_reg, ex_alu_out,
                      read_data_s, ex_return_pc, ex_write_src_sel};
      end
   end

endmodule

// File: tb/tb_memory_access.sv
// Directed self-checking bench for memory_access: loads, stores, wait states,
// illegal accesses and asynchronous reset during an outstanding access.
module tb_memory_access;

   logic          clk;
   logic          rstn;
   logic          ex_valid;
   logic          ex_write_en;
   logic [4:0]    ex_write_reg;
   logic [31:0]   ex_alu_out;
   logic [31:0]   ex_store_data;
   logic [31:0]   ex_return_pc;
   logic [1:0]    ex_write_src_sel;
   logic          ex_mem_read;
   logic          ex_mem_write;
   logic [2:0]    ex_funct3;
   logic          mem_stall;
   logic          dmem_req;
   logic          dmem_we;
   logic [31:0]   dmem_addr;
   logic [31:0]   dmem_wdata;
   logic [3:0]    dmem_be;
   logic          dmem_ack;
   logic [31:0]   dmem_rdata;
   logic          misalign_err;
   logic [103:0]  mem_wb_reg;

   int checks = 0;
   int errors = 0;
   int req_cnt;
   int stall_cnt;

   memory_access dut (
      .clk              (clk),
      .rstn             (rstn),
      .ex_valid         (ex_valid),
      .ex_write_en      (ex_write_en),
      .ex_write_reg     (ex_write_reg),
      .ex_alu_out       (ex_alu_out),
      .ex_store_data    (ex_store_data),
      .ex_return_pc     (ex_return_pc),
      .ex_write_src_sel (ex_write_src_sel),
      .ex_mem_read      (ex_mem_read),
      .ex_mem_write     (ex_mem_write),
      .ex_funct3        (ex_funct3),
      .mem_stall        (mem_stall),
      .dmem_req         (dmem_req),
      .dmem_we          (dmem_we),
      .dmem_addr        (dmem_addr),
      .dmem_wdata       (dmem_wdata),
      .dmem_be          (dmem_be),
      .dmem_ack         (dmem_ack),
      .dmem_rdata       (dmem_rdata),
      .misalign_err     (misalign_err),
      .mem_wb_reg       (mem_wb_reg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [103:0] obs, input logic [103:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic wen, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] sd, input logic [31:0] rpc,
                        input logic [1:0] sel, input logic lr, input logic sw,
                        input logic [2:0] f3, input logic ack, input logic [31:0] rdata);
      ex_valid = v; ex_write_en = wen; ex_write_reg = rd; ex_alu_out = alu;
      ex_store_data = sd; ex_return_pc = rpc; ex_write_src_sel = sel;
      ex_mem_read = lr; ex_mem_write = sw; ex_funct3 = f3;
      dmem_ack = ack; dmem_rdata = rdata;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rstn = 1'b0;
      drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 3'b000, 1'b0, 32'h0);
      #12;
      check("rst_wb", mem_wb_reg, 104'd0);
      check("rst_err", {103'd0, misalign_err}, 104'd0);
      check("rst_req", {103'd0, dmem_req}, 104'd0);
      @(negedge clk);
      rstn = 1'b1;

      // 1: LW zero-wait
      @(negedge clk);
      drive(1'b1, 1'b1, 5'd5, 32'h100, 32'h0, 32'h104, 2'd1, 1'b1, 1'b0, 3'b010, 1'b1, 32'hDEADBEEF);
      #1;
      check("t1_req", {103'd0, dmem_req}, 104'd1);
      check("t1_stall", {103'd0, mem_stall}, 104'd0);
      check("t1_addr", {72'd0, dmem_addr}, {72'd0, 32'h100});
      check("t1_be", {100'd0, dmem_be}, 104'd0);
      tick();
      check("t1_wb", mem_wb_reg, {1'b1, 5'd5, 32'h100, 32'hDEADBEEF, 32'h104, 2'd1});
      check("t1_state", {103'd0, dut.state_r}, 104'd0);

      // 2: byte/half load formatting
      @(negedge clk);
      drive(1'b1, 1'b1, 5'd6, 32'h103, 32'h0, 32'h0, 2'd1, 1'b1, 1'b0, 3'b000, 1'b1, 32'h80FF0000);
      tick();
      check("t2_lb", {72'd0, mem_wb_reg[65:34]}, {72'd0, 32'hFFFFFF80});
      @(negedge clk);
      ex_funct3 = 3'b100;
      tick();
      check("t2_lbu", {72'd0, mem_wb_reg[65:34]}, {72'd0, 32'h00000080});
      @(negedge clk);
      ex_alu_out = 32'h102; ex_funct3 = 3'b101;
      tick();
      check("t2_lhu", {72'd0, mem_wb_reg[65:34]}, {72'd0, 32'h000080FF});
      @(negedge clk);
      ex_funct3 = 3'b001;
      tick();
      check("t2_lh", {72'd0, mem_wb_reg[65:34]}, {72'd0, 32'hFFFF80FF});

      // 3: stores
      @(negedge clk);
      drive(1'b1, 1'b0, 5'd0, 32'h102, 32'h1234ABCD, 32'h0, 2'd0, 1'b0, 1'b1, 3'b001, 1'b1, 32'h0);
      #1;
      check("t3_we", {103'd0, dmem_we}, 104'd1);
      check("t3_addr", {72'd0, dmem_addr}, {72'd0, 32'h100});
      check("t3_wdata", {72'd0, dmem_wdata}, {72'd0, 32'hABCDABCD});
      check("t3_be", {100'd0, dmem_be}, {100'd0, 4'b1100});
      tick();
      check("t3_wen", {103'd0, mem_wb_reg[103]}, 104'd0);
      check("t3_rdata0", {72'd0, mem_wb_reg[65:34]}, 104'd0);
      @(negedge clk);
      ex_alu_out = 32'h101; ex_store_data = 32'h00000055; ex_funct3 = 3'b000;
      #1;
      check("t3_sb_wdata", {72'd0, dmem_wdata}, {72'd0, 32'h55555555});
      check("t3_sb_be", {100'd0, dmem_be}, {100'd0, 4'b0010});
      @(negedge clk);
      ex_alu_out = 32'h104; ex_store_data = 32'hA5A5_0F0F; ex_funct3 = 3'b010;
      #1;
      check("t3_sw_wdata", {72'd0, dmem_wdata}, {72'd0, 32'hA5A50F0F});
      check("t3_sw_be", {100'd0, dmem_be}, {100'd0, 4'b1111});

      // 4: LW with ack on the 4th request cycle
      req_cnt = 0;
      stall_cnt = 0;
      @(negedge clk);
      drive(1'b1, 1'b1, 5'd7, 32'h200, 32'h0, 32'h108, 2'd1, 1'b1, 1'b0, 3'b010, 1'b0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         dmem_ack = (i == 3);
         dmem_rdata = (i == 3) ? 32'h11223344 : 32'hFFFFFFFF;
         #1;
         if (dmem_req) req_cnt++;
         if (mem_stall) stall_cnt++;
         tick();
         if (i < 3) begin
            check("t4_bubble", mem_wb_reg, 104'd0);
            check("t4_wait", {103'd0, dut.state_r}, 104'd1);
         end
      end
      check("t4_req_cnt", 104'(req_cnt), 104'd4);
      check("t4_stall_cnt", 104'(stall_cnt), 104'd3);
      check("t4_wb", mem_wb_reg, {1'b1, 5'd7, 32'h200, 32'h11223344, 32'h108, 2'd1});
      check("t4_idle", {103'd0, dut.state_r}, 104'd0);

      // 5: misaligned LW, then illegal funct3, then a legal op
      @(negedge clk);
      drive(1'b1, 1'b1, 5'd8, 32'h102, 32'h0, 32'h0, 2'd1, 1'b1, 1'b0, 3'b010, 1'b1, 32'h12345678);
      #1;
      check("t5_noreq", {103'd0, dmem_req}, 104'd0);
      check("t5_nostall", {103'd0, mem_stall}, 104'd0);
      tick();
      check("t5_err", {103'd0, misalign_err}, 104'd1);
      check("t5_wen", {103'd0, mem_wb_reg[103]}, 104'd0);
      @(negedge clk);
      drive(1'b1, 1'b1, 5'd9, 32'h104, 32'h0, 32'h0, 2'd1, 1'b1, 1'b0, 3'b011, 1'b1, 32'h0);
      #1;
      check("t5_f3_noreq", {103'd0, dmem_req}, 104'd0);
      @(negedge clk);
      ex_funct3 = 3'b010;
      #1;
      check("t5_legal_req", {103'd0, dmem_req}, 104'd1);
      tick();
      check("t5_err_sticky", {103'd0, misalign_err}, 104'd1);
      check("t5_legal_wen", {103'd0, mem_wb_reg[103]}, 104'd1);

      // 6: reset during the 2nd wait cycle
      @(negedge clk);
      drive(1'b1, 1'b1, 5'd10, 32'h300, 32'h0, 32'h0, 2'd1, 1'b1, 1'b0, 3'b010, 1'b0, 32'h0);
      tick();
      tick();
      check("t6_in_wait", {103'd0, dut.state_r}, 104'd1);
      check("t6_stall_pre", {103'd0, mem_stall}, 104'd1);
      #2;
      rstn = 1'b0;
      #1;
      check("t6_req0", {103'd0, dmem_req}, 104'd0);
      check("t6_stall0", {103'd0, mem_stall}, 104'd0);
      check("t6_wb0", mem_wb_reg, 104'd0);
      check("t6_err0", {103'd0, misalign_err}, 104'd0);
      check("t6_idle", {103'd0, dut.state_r}, 104'd0);
      @(negedge clk);
      drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 3'b000, 1'b0, 32'h0);
      rstn = 1'b1;
      #1;
      check("t6_post_req", {103'd0, dmem_req}, 104'd0);
      tick();
      check("t6_post_idle", {103'd0, dut.state_r}, 104'd0);
      check("t6_post_wb", mem_wb_reg, 104'd0);

      // 6b: asynchronous clear of a populated MEM/WB register
      @(negedge clk);
      drive(1'b1, 1'b1, 5'd3, 32'h300, 32'h0, 32'h10C, 2'd1, 1'b1, 1'b0, 3'b010, 1'b1, 32'hCAFEF00D);
      tick();
      check("t6b_wb", mem_wb_reg, {1'b1, 5'd3, 32'h300, 32'hCAFEF00D, 32'h10C, 2'd1});
      #1;
      rstn = 1'b0;
      #1;
      check("t6b_wb_clr", mem_wb_reg, 104'd0);
      @(negedge clk);
      rstn = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- MEM stage of the 5-stage RISC-V pipeline, between execute and writeback.
- Issues loads and stores (byte, half and word) to data memory over a req/ack handshake that may take wait states.
- Formats load data and stalls upstream while a memory access is outstanding.
- Owns the MEM/WB pipeline register that feeds the writeback stage.

Parameters:
- REG_WIDTH, 32, datapath width. Only 32 is supported, because byte enables are 4 bits.
- REG_COUNT, 32, number of architectural registers.
- REG_BITS, $clog2(REG_COUNT), register index width.

Ports:
- clk  input  1  clock
- rstn  input  1  reset, asynchronous, active-low
- ex_valid  input  1  EX/MEM holds a valid instruction
- ex_write_en  input  1  instruction writes rd
- ex_write_reg  input  REG_BITS  rd index
- ex_alu_out  input  REG_WIDTH  ALU result; memory address for loads and stores
- ex_store_data  input  REG_WIDTH  rs2 value for stores
- ex_return_pc  input  REG_WIDTH  PC+4 for jumps
- ex_write_src_sel  input  2  0=ALU, 1=memory, 2=return PC
- ex_mem_read  input  1  load
- ex_mem_write  input  1  store
- ex_funct3  input  3  access size and sign
- mem_stall  output  1  hold the IF/ID/EX stages and the EX/MEM register
- dmem_req  output  1  memory request
- dmem_we  output  1  write request
- dmem_addr  output  REG_WIDTH  word-aligned address ({ex_alu_out[31:2],2'b00})
- dmem_wdata  output  REG_WIDTH  lane-replicated store data
- dmem_be  output  4  byte enables
- dmem_ack  input  1  request accepted; dmem_rdata is valid in the same cycle
- dmem_rdata  input  REG_WIDTH  read word
- misalign_err  output  1  sticky flag for a misaligned or illegal access
- mem_wb_reg  output  1+REG_BITS+3*REG_WIDTH+2  packed {write_en, write_reg, alu_out, mem_read_data, return_pc, write_src_sel}, MSB first

Behaviour:
- Memory op: mem_op = ex_valid & (ex_mem_read | ex_mem_write) & legal.
- Legal access:
  - funct3 000/100: always legal.
  - funct3 001/101: legal only when addr[0]=0.
  - funct3 010: legal only when addr[1:0]=00.
  - Stores accept only 000/001/010.
  - Anything else is illegal.
- Illegal access:
  - No dmem_req is issued.
  - misalign_err is set to 1 and stays set until reset.
  - The MEM/WB entry is written with write_en=0.
- Request and stall:
  - dmem_req = mem_op & rstn.
  - dmem_we = ex_mem_write.
  - mem_stall = mem_op & ~dmem_ack.
  - Upstream holds all ex_* inputs stable while mem_stall=1.
- FSM, states IDLE and WAIT:
  - IDLE -> WAIT when mem_op & ~dmem_ack.
  - WAIT -> IDLE on dmem_ack.
  - A zero-wait ack completes the access in the same cycle and the FSM stays in IDLE.
  - dmem_req stays high in WAIT until ack.
- Store formatting:
  - SB: wdata = {4{sd[7:0]}}, be = 0001 << addr[1:0].
  - SH: wdata = {2{sd[15:0]}}, be = 0011 << (2*addr[1]).
  - SW: wdata = sd, be = 1111.
- Load formatting: shift dmem_rdata right by 8*addr[1:0], then extend.
  - LB: sign-extend bits [7:0].
  - LBU: zero-extend bits [7:0].
  - LH: sign-extend bits [15:0].
  - LHU: zero-extend bits [15:0].
  - LW: full word.
- Outputs when there is no load: dmem_wdata and dmem_be = 0 when not a store; mem_read_data = 0 when not a load.
- MEM/WB register, updated on every clk rising edge:
  - mem_stall=1 or ex_valid=0: load a bubble (all fields 0).
  - Otherwise: load the ex_* fields plus the formatted read data, with write_en = ex_write_en & legal.
  - Latency: one cycle from access completion to mem_wb_reg.
- Reset (rstn=0, at any time including in WAIT):
  - FSM goes to IDLE immediately.
  - mem_wb_reg = 0, misalign_err = 0.
  - dmem_req and mem_stall are forced to 0 combinationally.
  - A pending access is abandoned with no retry after reset.
- Stores never write rd: EX clears ex_write_en for stores; this block does not check it.

Test Plan:
1. LW at 0x100, ack in the same cycle, rdata 0xDEADBEEF, sel=1, rd=5 -> mem_stall never asserts. Next cycle mem_wb_reg = {1, 5, 0x100, 0xDEADBEEF, pc+4, 1}.
2. LB at 0x103 with rdata 0x80FF0000 -> mem_read_data 0xFFFFFF80. LBU at the same address -> 0x00000080. LHU at 0x102 -> 0x000080FF.
3. SH at 0x102, store_data 0x1234ABCD -> dmem_we=1, dmem_addr 0x100, dmem_wdata 0xABCDABCD, dmem_be 1100. The MEM/WB entry has write_en=0.
4. LW with ack arriving on the 4th request cycle -> dmem_req high for 4 cycles and mem_stall high for 3. mem_wb_reg gets 3 bubbles, then the load result. FSM sequence: IDLE, WAIT, WAIT, WAIT, IDLE.
5. LW at 0x102 -> dmem_req stays 0, misalign_err=1 and remains 1 through later legal ops. The MEM/WB entry has write_en=0.
6. rstn dropped in WAIT (2nd wait cycle) -> dmem_req, mem_stall and mem_wb_reg go to 0 without a clock edge. After release, ack=0 and ex_valid=0 -> no request issued, FSM in IDLE.
